// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: words, register indices, the decoded control
// word and the IF/ID queue entry.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic [3:0] {
    op_br   = 4'h0,
    op_add  = 4'h1,
    op_ldb  = 4'h2,
    op_stb  = 4'h3,
    op_jsr  = 4'h4,
    op_and  = 4'h5,
    op_ldr  = 4'h6,
    op_str  = 4'h7,
    op_rti  = 4'h8,
    op_not  = 4'h9,
    op_ldi  = 4'hA,
    op_sti  = 4'hB,
    op_jmp  = 4'hC,
    op_shf  = 4'hD,
    op_lea  = 4'hE,
    op_trap = 4'hF
  } lc3b_opcode;

  typedef enum logic [1:0] {
    pcmux_inc  = 2'd0,
    pcmux_br   = 2'd1,
    pcmux_jmp  = 2'd2,
    pcmux_trap = 2'd3
  } lc3b_pcmux_sel;

  // Packs into exactly one 16-bit word so it can travel alongside instr/pc.
  typedef struct packed {
    lc3b_opcode    opcode;
    logic          load_regfile;
    logic          load_cc;
    logic          mem_read;
    logic          mem_write;
    logic [2:0]    alu_op;
    logic          sr2mux_sel;
    lc3b_pcmux_sel pcmux_sel;
    logic          marmux_sel;
    logic          br_en;
  } lc3b_control_word;

  typedef struct packed {
    lc3b_word         instr;
    lc3b_word         pc;
    lc3b_control_word ctrl;
  } ifid_entry_t;

  localparam lc3b_word         NOP_INSTR = 16'h0000;
  localparam lc3b_control_word CTRL_NONE = '0;

  // An all-zero instruction is a bubble, not a never-taken BR, so it must not
  // carry any control side effects down the pipe.
  function automatic lc3b_control_word filter_ctrl(input lc3b_word instr,
                                                   input lc3b_control_word ctrl);
    return (instr == NOP_INSTR) ? CTRL_NONE : ctrl;
  endfunction

endpackage

// File: rtl/ifid_queue_if.sv
// Fetch-to-decode handshake bundle. master = surrounding pipeline (producer
// and consumer), slave = the queue itself.
interface ifid_queue_if #(
  parameter int DEPTH = 4
);
  import lc3b_types::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  lc3b_word         in_instr;
  lc3b_word         in_pc;
  lc3b_control_word in_ctrl;

  logic             out_valid;
  logic             out_ready;
  lc3b_word         out_pc;
  lc3b_word         out_imm5;
  lc3b_word         out_imm4;
  lc3b_word         out_offset6;
  lc3b_word         out_offset9;
  lc3b_word         out_offset11;
  lc3b_word         out_trapvect8;
  lc3b_reg          out_dest;
  lc3b_reg          out_src1;
  lc3b_reg          out_src2;
  lc3b_control_word out_ctrl;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_instr, in_pc, in_ctrl, out_ready,
    input  in_ready, out_valid, out_pc, out_imm5, out_imm4, out_offset6,
           out_offset9, out_offset11, out_trapvect8, out_dest, out_src1,
           out_src2, out_ctrl, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_ctrl, out_ready,
    output in_ready, out_valid, out_pc, out_imm5, out_imm4, out_offset6,
           out_offset9, out_offset11, out_trapvect8, out_dest, out_src1,
           out_src2, out_ctrl, count
  );

endinterface

// File: rtl/ifid_decode.sv
// Purely combinational field extraction for one IF/ID entry; shared by the
// queue head and the optional bypass path.
module ifid_decode
  import lc3b_types::*;
#(
  parameter int PC_INC = 2
) (
  input  ifid_entry_t      entry,
  output lc3b_word         pc_next,
  output lc3b_word         imm5,
  output lc3b_word         imm4,
  output lc3b_word         offset6,
  output lc3b_word         offset9,
  output lc3b_word         offset11,
  output lc3b_word         trapvect8,
  output lc3b_reg          dest,
  output lc3b_reg          src1,
  output lc3b_reg          src2,
  output lc3b_control_word ctrl
);

  lc3b_word instr;
  logic     unused_opcode_bits;

  assign instr = entry.instr;

  // The opcode already lives in the control word; the raw bits are not needed here.
  assign unused_opcode_bits = ^instr[15:12];

  assign pc_next   = entry.pc + 16'(PC_INC);
  assign dest      = instr[11:9];
  assign src1      = instr[8:6];
  assign src2      = instr[2:0];
  assign imm5      = {{11{instr[4]}}, instr[4:0]};
  assign imm4      = {12'b0, instr[3:0]};
  assign offset6   = {{9{instr[5]}}, instr[5:0], 1'b0};
  assign offset9   = {{6{instr[8]}}, instr[8:0], 1'b0};
  assign offset11  = {{4{instr[10]}}, instr[10:0], 1'b0};
  assign trapvect8 = {7'b0, instr[7:0], 1'b0};
  assign ctrl      = entry.ctrl;

endmodule

// File: rtl/ifid_queue.sv
// Circular IF/ID buffer with valid/ready on both sides and decoded head fields.
// Define IFID_QUEUE_BYPASS_EN to let an empty queue forward in_* the same cycle.
module ifid_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_INC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  ifid_queue_if.slave bus
);
  import lc3b_types::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ifid_entry_t      mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;

  logic             queue_empty;
  logic             in_ready;
  logic             out_valid;
  logic             bypass_take;
  logic             push;
  logic             pop;
  ifid_entry_t      in_entry;
  ifid_entry_t      dec_entry;

  lc3b_word         dec_pc;
  lc3b_word         dec_imm5;
  lc3b_word         dec_imm4;
  lc3b_word         dec_offset6;
  lc3b_word         dec_offset9;
  lc3b_word         dec_offset11;
  lc3b_word         dec_trapvect8;
  lc3b_reg          dec_dest;
  lc3b_reg          dec_src1;
  lc3b_reg          dec_src2;
  lc3b_control_word dec_ctrl;

  assign queue_empty = (count_q == '0);
  assign in_ready    = (count_q < CW'(DEPTH));
  assign in_entry    = '{instr: bus.in_instr,
                         pc:    bus.in_pc,
                         ctrl:  filter_ctrl(bus.in_instr, bus.in_ctrl)};

`ifdef IFID_QUEUE_BYPASS_EN
  logic bypass_sel;

  // An empty queue shows the incoming entry directly; if it is consumed in the
  // same cycle it never occupies a slot.
  assign bypass_sel  = queue_empty && bus.in_valid && !flush;
  assign bypass_take = bypass_sel && bus.out_ready;
  assign out_valid   = !queue_empty || bypass_sel;
  assign dec_entry   = bypass_sel ? in_entry : mem[rd_ptr];
`else
  assign bypass_take = 1'b0;
  assign out_valid   = !queue_empty;
  assign dec_entry   = mem[rd_ptr];
`endif

  assign push = bus.in_valid && in_ready && !flush && !bypass_take;
  assign pop  = !queue_empty && bus.out_ready && !flush;

  ifid_decode #(
    .PC_INC (PC_INC)
  ) u_decode (
    .entry     (dec_entry),
    .pc_next   (dec_pc),
    .imm5      (dec_imm5),
    .imm4      (dec_imm4),
    .offset6   (dec_offset6),
    .offset9   (dec_offset9),
    .offset11  (dec_offset11),
    .trapvect8 (dec_trapvect8),
    .dest      (dec_dest),
    .src1      (dec_src1),
    .src2      (dec_src2),
    .ctrl      (dec_ctrl)
  );

  // Flush wins over everything, so a push or pop in the flush cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.count         = count_q;

  // Data outputs read as zero whenever nothing valid is on offer.
  assign bus.out_pc        = out_valid ? dec_pc        : '0;
  assign bus.out_imm5      = out_valid ? dec_imm5      : '0;
  assign bus.out_imm4      = out_valid ? dec_imm4      : '0;
  assign bus.out_offset6   = out_valid ? dec_offset6   : '0;
  assign bus.out_offset9   = out_valid ? dec_offset9   : '0;
  assign bus.out_offset11  = out_valid ? dec_offset11  : '0;
  assign bus.out_trapvect8 = out_valid ? dec_trapvect8 : '0;
  assign bus.out_dest      = out_valid ? dec_dest      : '0;
  assign bus.out_src1      = out_valid ? dec_src1      : '0;
  assign bus.out_src2      = out_valid ? dec_src2      : '0;
  assign bus.out_ctrl      = out_valid ? dec_ctrl      : '0;

endmodule

// File: tb/tb_ifid_queue.sv
// Scoreboard bench for ifid_queue (DEPTH=4, PC_INC=2): directed pushes queue
// their expected decode, a negedge monitor checks every accepted pop.
module tb_ifid_queue;
  import lc3b_types::*;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] imm5;
    logic [15:0] imm4;
    logic [15:0] off6;
    logic [15:0] off9;
    logic [15:0] off11;
    logic [15:0] trap;
    logic [15:0] ctrl;
    logic [2:0]  dest;
    logic [2:0]  src1;
    logic [2:0]  src2;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;
  exp_t sb[$];

  ifid_queue_if #(.DEPTH(4)) q_if ();

  ifid_queue #(
    .DEPTH  (4),
    .PC_INC (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (q_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written in plain two's-complement integer arithmetic.
  function automatic exp_t model(input logic [15:0] instr, input logic [15:0] pc,
                                 input logic [15:0] ctrl);
    exp_t e;
    int   v;
    e.pc   = pc + 16'd2;
    e.dest = instr[11:9];
    e.src1 = instr[8:6];
    e.src2 = instr[2:0];
    v = int'(instr[4:0]);  if (v >= 16)   v -= 32;   e.imm5  = 16'(v);
    v = int'(instr[3:0]);                            e.imm4  = 16'(v);
    v = int'(instr[5:0]);  if (v >= 32)   v -= 64;   e.off6  = 16'(v * 2);
    v = int'(instr[8:0]);  if (v >= 256)  v -= 512;  e.off9  = 16'(v * 2);
    v = int'(instr[10:0]); if (v >= 1024) v -= 2048; e.off11 = 16'(v * 2);
    v = int'(instr[7:0]);                            e.trap  = 16'(v * 2);
    e.ctrl = (instr == 16'h0000) ? 16'h0000 : ctrl;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Called one time unit after a rising edge; returns one unit after the next.
  task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] pc,
                               input logic [15:0] ctrl, input logic expect_accept);
    q_if.in_valid = 1'b1;
    q_if.in_instr = instr;
    q_if.in_pc    = pc;
    q_if.in_ctrl  = lc3b_control_word'(ctrl);
    if (expect_accept) sb.push_back(model(instr, pc, ctrl));
    @(negedge clk);
    checkOutput("in_ready", 16'(q_if.in_ready), 16'(expect_accept));
    @(posedge clk);
    #1;
    q_if.in_valid = 1'b0;
  endtask

  // Monitor: anything the consumer accepts must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !flush && q_if.out_valid && q_if.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pop: got pc %h, expected no entry", q_if.out_pc);
        end else begin
          e = sb.pop_front();
          checkOutput("mon_pc",    q_if.out_pc,        e.pc);
          checkOutput("mon_dest",  16'(q_if.out_dest), 16'(e.dest));
          checkOutput("mon_src1",  16'(q_if.out_src1), 16'(e.src1));
          checkOutput("mon_src2",  16'(q_if.out_src2), 16'(e.src2));
          checkOutput("mon_imm5",  q_if.out_imm5,      e.imm5);
          checkOutput("mon_imm4",  q_if.out_imm4,      e.imm4);
          checkOutput("mon_off6",  q_if.out_offset6,   e.off6);
          checkOutput("mon_off9",  q_if.out_offset9,   e.off9);
          checkOutput("mon_off11", q_if.out_offset11,  e.off11);
          checkOutput("mon_trap",  q_if.out_trapvect8, e.trap);
          checkOutput("mon_ctrl",  16'(q_if.out_ctrl), e.ctrl);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    flush          = 1'b0;
    q_if.in_valid  = 1'b0;
    q_if.in_instr  = '0;
    q_if.in_pc     = '0;
    q_if.in_ctrl   = '0;
    q_if.out_ready = 1'b0;

    @(negedge clk);
    checkOutput("rst_out_valid", 16'(q_if.out_valid), 16'h0);
    checkOutput("rst_in_ready",  16'(q_if.in_ready),  16'h1);
    checkOutput("rst_count",     16'(q_if.count),     16'h0);
    checkOutput("rst_out_pc",    q_if.out_pc,         16'h0);
    checkOutput("rst_out_trap",  q_if.out_trapvect8,  16'h0);
    checkOutput("rst_out_ctrl",  16'(q_if.out_ctrl),  16'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

`ifndef IFID_QUEUE_BYPASS_EN
    // Basic push with one cycle of latency and register-field extraction.
    q_if.out_ready = 1'b1;
    q_if.in_valid  = 1'b1;
    q_if.in_instr  = 16'h1283;
    q_if.in_pc     = 16'h3000;
    q_if.in_ctrl   = lc3b_control_word'(16'h1234);
    sb.push_back(model(16'h1283, 16'h3000, 16'h1234));
    @(negedge clk);
    checkOutput("latency_empty", 16'(q_if.out_valid), 16'h0);
    @(posedge clk);
    #1 q_if.in_valid = 1'b0;
    checkOutput("p1_valid", 16'(q_if.out_valid), 16'h1);
    checkOutput("p1_pc",    q_if.out_pc,         16'h3002);
    checkOutput("p1_dest",  16'(q_if.out_dest),  16'h1);
    checkOutput("p1_src1",  16'(q_if.out_src1),  16'h2);
    checkOutput("p1_src2",  16'(q_if.out_src2),  16'h3);
    @(posedge clk);
    #1;

    // All-zero instruction is a bubble: its control word is dropped.
    applyStimulus(16'h0000, 16'h5000, 16'hBEEF, 1'b1);
    checkOutput("nop_valid", 16'(q_if.out_valid), 16'h1);
    checkOutput("nop_ctrl",  16'(q_if.out_ctrl),  16'h0);
    @(posedge clk);
    #1;
`else
    q_if.out_ready = 1'b1;
    q_if.in_valid  = 1'b1;
    q_if.in_instr  = 16'h1283;
    q_if.in_pc     = 16'h3000;
    q_if.in_ctrl   = lc3b_control_word'(16'h1234);
    sb.push_back(model(16'h1283, 16'h3000, 16'h1234));
    #1;
    checkOutput("byp_valid", 16'(q_if.out_valid), 16'h1);
    checkOutput("byp_pc",    q_if.out_pc,         16'h3002);
    @(posedge clk);
    #1 q_if.in_valid = 1'b0;
    checkOutput("byp_count", 16'(q_if.count), 16'h0);
    @(posedge clk);
    #1;
`endif

    // Fill to capacity while stalled, try an overflow push, then drain in order.
    q_if.out_ready = 1'b0;
    applyStimulus(16'hF025, 16'h1000, 16'hF001, 1'b1);
    applyStimulus(16'h0FFF, 16'h2000, 16'h0E02, 1'b1);
    applyStimulus(16'h1283, 16'hFFFE, 16'h1103, 1'b1);
    applyStimulus(16'h5ABC, 16'h4000, 16'h5204, 1'b1);
    checkOutput("full_count",    16'(q_if.count),    16'h4);
    checkOutput("full_in_ready", 16'(q_if.in_ready), 16'h0);
    checkOutput("full_trap",     q_if.out_trapvect8, 16'h004A);
    applyStimulus(16'h7777, 16'h7000, 16'h7005, 1'b0);
    checkOutput("hold_count", 16'(q_if.count),    16'h4);
    checkOutput("hold_trap",  q_if.out_trapvect8, 16'h004A);
    checkOutput("hold_pc",    q_if.out_pc,        16'h1002);
    q_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("neg_off9", q_if.out_offset9, 16'hFFFE);
    checkOutput("neg_imm5", q_if.out_imm5,    16'hFFFF);
    checkOutput("neg_off6", q_if.out_offset6, 16'hFFFE);
    @(posedge clk);
    #1;
    checkOutput("wrap_valid", 16'(q_if.out_valid), 16'h1);
    checkOutput("wrap_pc",    q_if.out_pc,         16'h0000);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("drain_count", 16'(q_if.count),      16'h0);
    checkOutput("drain_valid", 16'(q_if.out_valid),  16'h0);
    checkOutput("idle_off11",  q_if.out_offset11,    16'h0);
    checkOutput("idle_ctrl",   16'(q_if.out_ctrl),   16'h0);
    checkOutput("idle_src1",   16'(q_if.out_src1),   16'h0);

    // Back-to-back traffic: a simultaneous push and pop leaves occupancy alone.
    applyStimulus(16'h1A42, 16'h0100, 16'h1010, 1'b1);
    applyStimulus(16'h2B53, 16'h0102, 16'h2020, 1'b1);
`ifdef IFID_QUEUE_BYPASS_EN
    checkOutput("pushpop_count", 16'(q_if.count), 16'h0);
`else
    checkOutput("pushpop_count", 16'(q_if.count), 16'h1);
`endif
    @(posedge clk);
    #1;

    // Flush with three buffered and one arriving entry discards all of them.
    q_if.out_ready = 1'b0;
    applyStimulus(16'h3001, 16'h0200, 16'h3030, 1'b1);
    applyStimulus(16'h3002, 16'h0202, 16'h3031, 1'b1);
    applyStimulus(16'h3003, 16'h0204, 16'h3032, 1'b1);
    checkOutput("preflush_count", 16'(q_if.count), 16'h3);
    flush          = 1'b1;
    q_if.in_valid  = 1'b1;
    q_if.in_instr  = 16'h3004;
    q_if.in_pc     = 16'h0206;
    @(negedge clk);
    checkOutput("flush_in_ready", 16'(q_if.in_ready), 16'h1);
    @(posedge clk);
    sb.delete();
    #1;
    flush         = 1'b0;
    q_if.in_valid = 1'b0;
    checkOutput("flush_count", 16'(q_if.count),     16'h0);
    checkOutput("flush_valid", 16'(q_if.out_valid), 16'h0);
    q_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("flush_lost", 16'(q_if.out_valid), 16'h0);

    // Asynchronous reset in the middle of traffic empties the queue at once.
    q_if.out_ready = 1'b0;
    applyStimulus(16'h4101, 16'h0300, 16'h4040, 1'b1);
    applyStimulus(16'h4102, 16'h0302, 16'h4041, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_count",    16'(q_if.count),     16'h0);
    checkOutput("arst_valid",    16'(q_if.out_valid), 16'h0);
    checkOutput("arst_in_ready", 16'(q_if.in_ready),  16'h1);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    q_if.out_ready = 1'b1;
    applyStimulus(16'h6ABC, 16'h8000, 16'h6060, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    checkOutput("sb_drained", 16'(sb.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
